// File: rtl/dataproc_seq_ctrl.sv
// dataproc_seq_ctrl: memory-mapped sequencer for the pixel data-processing datapath.
// The CPU programs MODE/LENGTH, writes START, and the block then passes LENGTH source
// beats into the datapath. It collects results in a one-entry holder and reports
// completion through STATUS and a level interrupt.
module dataproc_seq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_1000,
    parameter int          CNT_W     = 16,
    parameter int          MODE_W    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    // iomem bus
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    // source stream
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [7:0]        src_data,
    // stream into the datapath
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic [7:0]        dp_data,
    output logic [MODE_W-1:0] dp_mode,
    // result stream from the datapath
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [7:0]        res_data,
    output logic              irq
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e             state_q, state_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic               irq_en_q, irq_en_d;
    logic [CNT_W-1:0]   length_q, length_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               res_valid_q, res_valid_d;
    logic [7:0]         res_byte_q, res_byte_d;
    logic               irq_q, irq_d;
    logic               ready_q, ready_d;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The access is performed on the ack cycle, while the master still holds
    // addr/wdata/wstrb stable.
    logic       in_win, acc, wr, rd;
    logic [1:0] reg_sel;
    logic       ctrl_wr, start_wr, abort_wr, status_wr, len_wr, pop;
    logic       run, beat, res_hs, last_beat;

    assign in_win    = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
    assign acc       = ready_q && in_win;
    assign wr        = acc && (iomem_wstrb != 4'b0000);
    assign rd        = acc && (iomem_wstrb == 4'b0000);
    assign reg_sel   = iomem_addr[3:2];
    assign ctrl_wr   = wr && (reg_sel == 2'd0) && iomem_wstrb[0];
    assign start_wr  = ctrl_wr && iomem_wdata[0];
    assign abort_wr  = ctrl_wr && iomem_wdata[1];
    assign status_wr = wr && (reg_sel == 2'd1) && iomem_wstrb[0];
    assign len_wr    = wr && (reg_sel == 2'd2);
    assign pop       = rd && (reg_sel == 2'd3) && res_valid_q;

    // The stream passes through combinationally, and only in RUN.
    assign run       = (state_q == S_RUN);
    assign dp_valid  = run && src_valid;
    assign src_ready = run && dp_ready;
    assign dp_data   = src_data;
    assign dp_mode   = mode_q;
    assign beat      = dp_valid && dp_ready;
    assign last_beat = (beat_cnt_q == length_q - CNT_W'(1));

    // The holder accepts a new byte when it is empty or being popped this cycle.
    assign res_ready = !res_valid_q || pop;
    assign res_hs    = res_valid && res_ready;

    assign iomem_ready = ready_q;
    assign irq         = irq_q;

    // Address bits below word granularity and wdata above LENGTH carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:CNT_W]};

    // Read data mux; drives zero outside the ack cycle.
    always_comb begin
        iomem_rdata = '0;
        if (ready_q && in_win) begin
            unique case (reg_sel)
                2'd0: begin
                    iomem_rdata[2 +: MODE_W] = mode_q;
                    iomem_rdata[4]           = irq_en_q;
                end
                2'd1: begin
                    iomem_rdata[0]          = (state_q != S_IDLE);
                    iomem_rdata[1]          = done_q;
                    iomem_rdata[2]          = aborted_q;
                    iomem_rdata[3]          = res_valid_q;
                    iomem_rdata[16 +: CNT_W] = beat_cnt_q;
                end
                2'd2: iomem_rdata[CNT_W-1:0] = length_q;
                default: iomem_rdata[8:0] = {res_valid_q, res_byte_q};
            endcase
        end
    end

    // Next-state logic for the registers, the result holder and the sequencer FSM.
    always_comb begin
        // NOTE: every _d defaults to its _q first so that no path leaves a latch behind.
        state_d     = state_q;
        mode_d      = mode_q;
        irq_en_d    = irq_en_q;
        length_d    = length_q;
        beat_cnt_d  = beat_cnt_q;
        res_cnt_d   = res_cnt_q;
        done_d      = done_q;
        aborted_d   = aborted_q;
        res_valid_d = res_valid_q;
        res_byte_d  = res_byte_q;
        irq_d       = irq_en_q && (done_q || aborted_q);
        ready_d     = in_win && !ready_q;

        if (ctrl_wr) begin
            irq_en_d = iomem_wdata[4];
            if (state_q == S_IDLE) mode_d = iomem_wdata[2 +: MODE_W];
        end
        if (len_wr && state_q == S_IDLE) begin
            for (int b = 0; b < CNT_W / 8; b++) begin
                if (iomem_wstrb[b]) length_d[8*b +: 8] = iomem_wdata[8*b +: 8];
            end
        end
        // W1C first, so a completion event in the same cycle wins.
        if (status_wr) begin
            if (iomem_wdata[1]) done_d    = 1'b0;
            if (iomem_wdata[2]) aborted_d = 1'b0;
        end

        if (res_hs) begin
            res_valid_d = 1'b1;
            res_byte_d  = res_data;
            if (state_q != S_IDLE) res_cnt_d = sat_inc(res_cnt_q);
        end else if (pop) begin
            res_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_wr && !abort_wr) begin
                    done_d     = 1'b0;
                    aborted_d  = 1'b0;
                    beat_cnt_d = '0;
                    res_cnt_d  = '0;
                    if (length_q == '0) done_d  = 1'b1;
                    else                state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (beat) beat_cnt_d = sat_inc(beat_cnt_q);
                if (abort_wr) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (beat && last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_wr) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (res_cnt_q >= length_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            irq_en_q    <= 1'b0;
            length_q    <= '0;
            beat_cnt_q  <= '0;
            res_cnt_q   <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_byte_q  <= '0;
            irq_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so that every flop samples pre-edge values.
            state_q     <= state_d;
            mode_q      <= mode_d;
            irq_en_q    <= irq_en_d;
            length_q    <= length_d;
            beat_cnt_q  <= beat_cnt_d;
            res_cnt_q   <= res_cnt_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            res_valid_q <= res_valid_d;
            res_byte_q  <= res_byte_d;
            irq_q       <= irq_d;
            ready_q     <= ready_d;
        end
    end

endmodule

// File: tb/tb_dataproc_seq_ctrl.sv
// Testbench for dataproc_seq_ctrl: a CPU bus model, a source driver, an echoing datapath
// model and a scoreboard of expected datapath bytes and RESULT bytes.
module tb_dataproc_seq_ctrl;

    localparam logic [31:0] BASE   = 32'h0200_1000;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_LEN  = BASE + 32'h8;
    localparam logic [31:0] A_RES  = BASE + 32'hC;

    logic        clk;
    logic        resetn;
    logic        iomem_valid, iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
    logic        src_valid, src_ready;
    logic [7:0]  src_data;
    logic        dp_valid, dp_ready;
    logic [7:0]  dp_data;
    logic [1:0]  dp_mode;
    logic        res_valid, res_ready;
    logic [7:0]  res_data;
    logic        irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_dp[$];
    logic [7:0]  exp_res[$];
    logic [7:0]  echo_q[$];
    int          dp_beats = 0;
    bit          dp_valid_seen = 0;
    int          dp_ready_sel = 1;
    logic [31:0] rv;

    dataproc_seq_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_data    (src_data),
        .dp_valid    (dp_valid),
        .dp_ready    (dp_ready),
        .dp_data     (dp_data),
        .dp_mode     (dp_mode),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // dp_ready driver: 0 = low, 1 = high, 2 = toggle every cycle
    initial begin
        dp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (dp_ready_sel)
                0:       dp_ready = 1'b0;
                1:       dp_ready = 1'b1;
                default: dp_ready = ~dp_ready;
            endcase
        end
    end

    // Datapath model: returns every byte queued in echo_q on the result stream
    initial begin
        res_valid = 1'b0;
        res_data  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (echo_q.size() > 0) begin
                res_valid = 1'b1;
                res_data  = echo_q[0];
            end else begin
                res_valid = 1'b0;
            end
            @(negedge clk);
            if (res_valid && res_ready && echo_q.size() > 0) void'(echo_q.pop_front());
        end
    end

    // Monitor of the datapath input stream against the scoreboard
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (dp_valid) dp_valid_seen = 1'b1;
            if (dp_valid && dp_ready) begin
                dp_beats++;
                check("dp_beat_expected", 32'(exp_dp.size() > 0), 32'd1);
                if (exp_dp.size() > 0) begin
                    e = exp_dp.pop_front();
                    check("dp_data", 32'(dp_data), 32'(e));
                end
                echo_q.push_back(dp_data);
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata);
        bit acked = 1'b0;
        rdata = '0;
        @(posedge clk); #1;
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        iomem_wstrb = strb;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (iomem_ready) begin
                acked = 1'b1;
                rdata = iomem_rdata;
                break;
            end
        end
        check("bus_ack", 32'(acked), 32'd1);
        @(posedge clk); #1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb = 4'hF);
        logic [31:0] dummy;
        bus_xfer(addr, data, strb, dummy);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_xfer(addr, 32'h0, 4'h0, data);
    endtask

    // Sends n bytes base, base+1, ... and records them as expected beats and results
    task automatic send_src(input int n, input logic [7:0] base, input bit rnd);
        bit hs;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                src_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            src_valid = 1'b1;
            src_data  = base + 8'(i);
            exp_dp.push_back(src_data);
            exp_res.push_back(src_data);
            hs = 1'b0;
            for (int t = 0; t < 64; t++) begin
                @(negedge clk);
                if (src_ready) begin hs = 1'b1; break; end
                @(posedge clk); #1;
            end
            check("src_handshake", 32'(hs), 32'd1);
            @(posedge clk); #1;
        end
        src_valid = 1'b0;
    endtask

    // CPU reads RESULT until n valid bytes have been compared with the scoreboard
    task automatic drain_results(input int n);
        int          got = 0;
        logic [31:0] r;
        logic [7:0]  e;
        for (int t = 0; t < 64 && got < n; t++) begin
            bus_read(A_RES, r);
            if (r[8]) begin
                check("result_expected", 32'(exp_res.size() > 0), 32'd1);
                e = (exp_res.size() > 0) ? exp_res.pop_front() : 8'h00;
                check("result_byte", 32'(r[7:0]), 32'(e));
                got++;
            end
        end
        check("results_drained", 32'(got), 32'(n));
    endtask

    task automatic wait_status(input logic [31:0] mask, output logic [31:0] r);
        bit seen = 1'b0;
        r = '0;
        for (int t = 0; t < 64; t++) begin
            bus_read(A_STAT, r);
            if ((r & mask) != 0) begin seen = 1'b1; break; end
        end
        check("status_wait", 32'(seen), 32'd1);
    endtask

    initial begin
        bit acked;
        bit seen;
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        src_valid   = 1'b0;
        src_data    = 8'h00;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_iomem_ready", 32'(iomem_ready), 32'd0);
        check("rst_iomem_rdata", iomem_rdata, 32'd0);
        check("rst_dp_valid",    32'(dp_valid), 32'd0);
        check("rst_src_ready",   32'(src_ready), 32'd0);
        check("rst_irq",         32'(irq), 32'd0);
        check("rst_dp_mode",     32'(dp_mode), 32'd0);
        check("rst_res_ready",   32'(res_ready), 32'd1);
        bus_read(A_STAT, rv); check("rst_status",  rv, 32'h0);
        bus_read(A_CTRL, rv); check("rst_control", rv, 32'h0);
        bus_read(A_LEN,  rv); check("rst_length",  rv, 32'h0);

        // Out-of-window access is never acknowledged
        @(posedge clk); #1;
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h10;
        iomem_wstrb = 4'h0;
        acked = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (iomem_ready) acked = 1'b1;
        end
        check("oow_no_ack", 32'(acked), 32'd0);
        @(posedge clk); #1;
        iomem_valid = 1'b0;

        // 1: basic run, LENGTH=4 via a byte-0-only write, MODE=2, IRQ_EN=1
        dp_beats = 0;
        bus_write(A_LEN, 32'h0000_AB04, 4'b0001);
        bus_read(A_LEN, rv);  check("t1_length_wstrb", rv, 32'h4);
        bus_write(A_CTRL, 32'h19);
        check("t1_dp_mode", 32'(dp_mode), 32'd2);
        bus_read(A_CTRL, rv); check("t1_control_rd", rv, 32'h18);
        send_src(4, 8'h10, 1'b0);
        drain_results(4);
        wait_status(32'h2, rv);
        check("t1_status", rv, 32'h0004_0002);
        @(negedge clk);
        check("t1_irq", 32'(irq), 32'd1);
        check("t1_beats", 32'(dp_beats), 32'd4);
        bus_write(A_STAT, 32'h2);

        // 2: LENGTH=6, dp_ready toggling, random source gaps
        dp_beats = 0;
        bus_write(A_LEN, 32'd6);
        bus_write(A_CTRL, 32'h19);
        dp_ready_sel = 2;
        send_src(6, 8'h40, 1'b1);
        dp_ready_sel = 1;
        check("t2_beats", 32'(dp_beats), 32'd6);
        check("t2_no_pending", 32'(exp_dp.size()), 32'd0);
        drain_results(6);
        wait_status(32'h2, rv);
        check("t2_status", rv, 32'h0006_0002);
        bus_write(A_STAT, 32'h2);

        // 3: LENGTH=8, ABORT after 2 beats; MODE and LENGTH locked while busy
        dp_beats = 0;
        bus_write(A_LEN, 32'd8);
        bus_write(A_CTRL, 32'h19);
        bus_write(A_CTRL, 32'h10);
        check("t3_mode_locked", 32'(dp_mode), 32'd2);
        bus_write(A_LEN, 32'd3);
        send_src(2, 8'h80, 1'b0);
        bus_write(A_CTRL, 32'h1A);
        src_valid = 1'b1;
        src_data  = 8'h99;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (dp_valid) seen = 1'b1;
        end
        check("t3_dp_valid_after_abort", 32'(seen), 32'd0);
        @(posedge clk); #1;
        src_valid = 1'b0;
        drain_results(2);
        bus_read(A_STAT, rv); check("t3_status", rv, 32'h0002_0004);
        bus_read(A_LEN, rv);  check("t3_length_locked", rv, 32'd8);
        check("t3_beats", 32'(dp_beats), 32'd2);
        @(negedge clk);
        check("t3_irq_set", 32'(irq), 32'd1);
        bus_write(A_STAT, 32'h4);
        @(posedge clk);
        @(negedge clk);
        check("t3_irq_cleared", 32'(irq), 32'd0);

        // 4: LENGTH=0 completes immediately without a beat
        bus_write(A_LEN, 32'd0);
        dp_valid_seen = 1'b0;
        bus_write(A_CTRL, 32'h19);
        bus_read(A_STAT, rv); check("t4_status", rv, 32'h0000_0002);
        check("t4_no_dp_valid", 32'(dp_valid_seen), 32'd0);
        bus_write(A_STAT, 32'h2);

        // 5: two results with no CPU read, then pop/load in the same cycle
        echo_q.push_back(8'hA5);
        echo_q.push_back(8'h3C);
        repeat (4) @(negedge clk);
        check("t5_res_ready_full", 32'(res_ready), 32'd0);
        bus_read(A_RES, rv); check("t5_res_a5",    rv, 32'h1A5);
        bus_read(A_RES, rv); check("t5_res_3c",    rv, 32'h13C);
        bus_read(A_RES, rv); check("t5_res_empty", rv, 32'h03C);

        // 6: asynchronous reset in the middle of RUN
        bus_write(A_LEN, 32'd8);
        bus_write(A_CTRL, 32'h19);
        send_src(3, 8'h20, 1'b0);
        dp_ready_sel = 0;
        @(posedge clk); #1;
        src_valid = 1'b1;
        src_data  = 8'h55;
        @(negedge clk);
        check("t6_dp_valid_before", 32'(dp_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t6_dp_valid",    32'(dp_valid), 32'd0);
        check("t6_src_ready",   32'(src_ready), 32'd0);
        check("t6_irq",         32'(irq), 32'd0);
        check("t6_iomem_ready", 32'(iomem_ready), 32'd0);
        check("t6_iomem_rdata", iomem_rdata, 32'd0);
        check("t6_dp_mode",     32'(dp_mode), 32'd0);
        check("t6_res_ready",   32'(res_ready), 32'd1);
        exp_dp.delete();
        exp_res.delete();
        echo_q.delete();
        src_valid = 1'b0;
        @(posedge clk); #3;
        resetn = 1'b1;
        dp_ready_sel = 1;
        bus_read(A_STAT, rv); check("t6_status", rv, 32'h0);
        bus_read(A_LEN,  rv); check("t6_length", rv, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
